syscall_sequencer: RTL
======================

SYSCALL_SEQUENCER -- requirements
Module: syscall_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1024: WAIT-state cycles allowed before a service is abandoned.
REQ-002 SHALL have port CLK  in  1  single system clock; all state changes on the rising edge.
REQ-003 SHALL have port Reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port Syscall  in  1  syscall instruction is present in the CPU this cycle.
REQ-005 SHALL have port R1  in  32  service code.
REQ-006 SHALL have port R2  in  32  service argument.
REQ-007 SHALL have port Go  in  1  resume button, level input.
REQ-008 SHALL have port SvcDone  in  1  handshake completion from the active peripheral.
REQ-009 SHALL have port KBValid / KBData  in  1 / 32  keyboard data available / keyboard data value.
REQ-010 SHALL have port Req_Screen, Req_Bitmap, Req_Copy, Req_Flush, Req_KB  out  1 each  one-cycle service request strobes.
REQ-011 SHALL have port Stall  out  1  freezes the CPU PC/pipeline.
REQ-012 SHALL have port LedData  out  32  LED display register.
REQ-013 SHALL have port Result / ResultWe  out  32 / 1  return value / write enable into the CPU register file.
REQ-014 SHALL have port Paused / Error  out  1 / 1  pause indicator / sticky fault flag.

Function
REQ-015 SHALL decode R1 as follows: 16 KB, 32 Screen, 33 Bitmap, 34 LED, 35 Copy, 36 Flush, 49 Cycles, 50 Pause; any other value is unknown.
REQ-016 SHALL implement the states IDLE, REQ, WAIT, PAUSE and DONE, and SHALL ignore Syscall in every state other than IDLE.
REQ-017 SHALL handle single-cycle codes in IDLE without stalling:
- LED: LedData <= R2 at the edge.
- Cycles: Result = CycCnt combinationally, with ResultWe=1 in the same cycle.
- Unknown code: Error <= 1, with no other effect.
REQ-018 SHALL, for multi-cycle codes (16, 32, 33, 35, 36, 50), drive Stall=1 combinationally in the Syscall cycle.
REQ-019 SHALL, for those codes, move IDLE->REQ on the edge, or IDLE->PAUSE for code 50.
REQ-020 SHALL assert Stall=1 in REQ, WAIT and PAUSE, and Stall=0 in DONE and IDLE.
REQ-021 SHALL latch the decoded service in IDLE so that it is held through REQ, WAIT, PAUSE and DONE.
REQ-022 SHALL pulse exactly one matching Req_* in REQ for exactly one cycle, then go to WAIT and clear the timeout counter.
REQ-023 SHALL leave WAIT for DONE when SvcDone=1, or when KBValid=1 for code 16; for code 16 it SHALL capture KBData into an internal register.
REQ-024 SHALL increment the timeout counter each WAIT cycle; on reaching TIMEOUT-1 without completion it SHALL set Error<=1, go to DONE and force captured data to 0.
REQ-025 SHALL let completion win when completion and timeout occur in the same cycle, leaving Error unchanged.
REQ-026 SHALL hold Paused=1 in PAUSE and leave PAUSE for DONE on a Go rising edge (Go registered, 0->1); a Go level that is already high on entry SHALL NOT release.
REQ-027 SHALL, in DONE, drive Result = captured KB data and ResultWe=1 for code 16 only (otherwise ResultWe=0), then return to IDLE; DONE lasts exactly one cycle.
REQ-028 SHALL keep CycCnt as a 32-bit free-running counter that increments every cycle except while Paused=1 and wraps 0xFFFFFFFF->0.
REQ-029 SHALL keep Error set until Reset.
REQ-030 SHALL drive Result=0 and ResultWe=0 whenever not otherwise specified.

Reset
REQ-031 SHALL, on Reset=1 (asynchronous, in any state including mid-WAIT or PAUSE), force:
- state IDLE, with Stall=0;
- all Req_*=0;
- LedData=0, Result=0, ResultWe=0;
- Paused=0, Error=0;
- CycCnt=0, timeout counter=0, captured data=0, Go history=0.
REQ-032 SHALL drive no strobe in the first cycle after Reset deasserts unless Syscall with a valid code is present.

Verification
REQ-033 LED case: Syscall=1, R1=34, R2=0x0000BEEF for 1 cycle -> LedData=0x0000BEEF after the edge, Stall=0 throughout, no Req_* strobe.
REQ-034 Copy case: R1=35 with SvcDone raised 3 cycles after Req_Copy -> Stall high for REQ + 3 WAIT cycles, Req_Copy exactly 1 cycle, DONE with Stall=0, IDLE next.
REQ-035 KB case: R1=16, KBValid=1 with KBData=0x41 on the 2nd WAIT cycle -> DONE cycle has Result=0x41 and ResultWe=1, Error stays 0.
REQ-036 Pause case: R1=50 with Go already high -> Paused remains 1 and CycCnt frozen; Go 0 then 1 -> DONE on the next edge, Paused=0, CycCnt resumes from its frozen value.
REQ-037 Timeout case: TIMEOUT=8, R1=36, SvcDone never asserted -> Error=1 after 8 WAIT cycles, then DONE and IDLE; unknown code R1=7 also sets Error.
REQ-038 Reset case: Reset asserted in WAIT during code 33 -> immediate IDLE, Stall=0, all outputs 0; a later Syscall R1=49 returns Result equal to the cycles counted since reset release.

Source files
------------

// File: rtl/syscall_sequencer.sv
// Syscall sequencer: decodes CPU syscall service codes, runs single-cycle
// services inline and sequences multi-cycle peripheral/pause services while
// stalling the CPU.
module syscall_sequencer #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        Syscall,
    input  logic [31:0] R1,
    input  logic [31:0] R2,
    input  logic        Go,
    input  logic        SvcDone,
    input  logic        KBValid,
    input  logic [31:0] KBData,
    output logic        Req_Screen,
    output logic        Req_Bitmap,
    output logic        Req_Copy,
    output logic        Req_Flush,
    output logic        Req_KB,
    output logic        Stall,
    output logic [31:0] LedData,
    output logic [31:0] Result,
    output logic        ResultWe,
    output logic        Paused,
    output logic        Error
);

    localparam int unsigned DW = 32;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [DW-1:0] CODE_KB     = DW'(16);
    localparam logic [DW-1:0] CODE_SCREEN = DW'(32);
    localparam logic [DW-1:0] CODE_BITMAP = DW'(33);
    localparam logic [DW-1:0] CODE_LED    = DW'(34);
    localparam logic [DW-1:0] CODE_COPY   = DW'(35);
    localparam logic [DW-1:0] CODE_FLUSH  = DW'(36);
    localparam logic [DW-1:0] CODE_CYCLES = DW'(49);
    localparam logic [DW-1:0] CODE_PAUSE  = DW'(50);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_PAUSE,
        ST_DONE
    } state_t;

    typedef enum logic [2:0] {
        SVC_NONE,
        SVC_KB,
        SVC_SCREEN,
        SVC_BITMAP,
        SVC_COPY,
        SVC_FLUSH,
        SVC_PAUSE
    } svc_t;

    state_t        state_q, state_d;
    svc_t          svc_q,   svc_d;
    logic [TW-1:0] to_q,    to_d;
    logic [DW-1:0] kb_q,    kb_d;
    logic [DW-1:0] led_q,   led_d;
    logic [DW-1:0] cyc_q,   cyc_d;
    logic          err_q,   err_d;
    logic          go_q,    go_d;
    logic          complete_c;

    assign LedData = led_q;
    assign Error   = err_q;
    assign Paused  = (state_q == ST_PAUSE);

    // Completion for the active service: peripheral handshake, or keyboard data for KB.
    assign complete_c = SvcDone || ((svc_q == SVC_KB) && KBValid);

    // Next-state and output decode.
    always_comb begin
        state_d    = state_q;
        svc_d      = svc_q;
        to_d       = to_q;
        kb_d       = kb_q;
        led_d      = led_q;
        err_d      = err_q;
        go_d       = Go;
        cyc_d      = Paused ? cyc_q : cyc_q + DW'(1);
        Stall      = 1'b0;
        Result     = '0;
        ResultWe   = 1'b0;
        Req_Screen = 1'b0;
        Req_Bitmap = 1'b0;
        Req_Copy   = 1'b0;
        Req_Flush  = 1'b0;
        Req_KB     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (Syscall) begin
                    case (R1)
                        CODE_LED: led_d = R2;
                        CODE_CYCLES: begin
                            Result   = cyc_q;
                            ResultWe = 1'b1;
                        end
                        CODE_KB: begin
                            Stall   = 1'b1;
                            svc_d   = SVC_KB;
                            state_d = ST_REQ;
                        end
                        CODE_SCREEN: begin
                            Stall   = 1'b1;
                            svc_d   = SVC_SCREEN;
                            state_d = ST_REQ;
                        end
                        CODE_BITMAP: begin
                            Stall   = 1'b1;
                            svc_d   = SVC_BITMAP;
                            state_d = ST_REQ;
                        end
                        CODE_COPY: begin
                            Stall   = 1'b1;
                            svc_d   = SVC_COPY;
                            state_d = ST_REQ;
                        end
                        CODE_FLUSH: begin
                            Stall   = 1'b1;
                            svc_d   = SVC_FLUSH;
                            state_d = ST_REQ;
                        end
                        CODE_PAUSE: begin
                            Stall   = 1'b1;
                            svc_d   = SVC_PAUSE;
                            state_d = ST_PAUSE;
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            ST_REQ: begin
                Stall      = 1'b1;
                Req_KB     = (svc_q == SVC_KB);
                Req_Screen = (svc_q == SVC_SCREEN);
                Req_Bitmap = (svc_q == SVC_BITMAP);
                Req_Copy   = (svc_q == SVC_COPY);
                Req_Flush  = (svc_q == SVC_FLUSH);
                to_d       = '0;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                Stall = 1'b1;
                // Completion takes priority over a coincident timeout.
                if (complete_c) begin
                    if ((svc_q == SVC_KB) && KBValid) begin
                        kb_d = KBData;
                    end
                    state_d = ST_DONE;
                end else if (to_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    kb_d    = '0;
                    state_d = ST_DONE;
                end else begin
                    to_d = to_q + TW'(1);
                end
            end
            ST_PAUSE: begin
                Stall = 1'b1;
                // Release only on a fresh 0->1 transition of Go.
                if (Go && !go_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (svc_q == SVC_KB) begin
                    Result   = kb_q;
                    ResultWe = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            svc_q   <= SVC_NONE;
            to_q    <= '0;
            kb_q    <= '0;
            led_q   <= '0;
            cyc_q   <= '0;
            err_q   <= 1'b0;
            go_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            svc_q   <= svc_d;
            to_q    <= to_d;
            kb_q    <= kb_d;
            led_q   <= led_d;
            cyc_q   <= cyc_d;
            err_q   <= err_d;
            go_q    <= go_d;
        end
    end

endmodule
